alu_issue_ctrl: RTL and testbench

Sequencing front-end that drives the 8-bit ALU's operand/opcode interface (a, b, op -> result). It accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 4x8 register file. It presents them to the ALU, captures the result and writes it back, one instruction at a time. It is the initiator of the ALU's combinational interface; the ALU itself stays outside this block.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction field
// positions, FSM state encoding and the opcode legality check.
package alu_pkg;

  localparam int unsigned NREGS = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned OPW   = 6;
  localparam int unsigned IW    = 16;

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_MUL   = 6'b000010;
  localparam logic [OPW-1:0] OP_DIV   = 6'b000011;
  localparam logic [OPW-1:0] OP_CMP   = 6'b000100;
  localparam logic [OPW-1:0] OP_NOT   = 6'b001000;
  localparam logic [OPW-1:0] OP_AND   = 6'b001001;
  localparam logic [OPW-1:0] OP_OR    = 6'b001010;
  localparam logic [OPW-1:0] OP_XOR   = 6'b001011;
  localparam logic [OPW-1:0] OP_SHL   = 6'b010000;
  localparam logic [OPW-1:0] OP_SHR   = 6'b010001;
  localparam logic [OPW-1:0] OP_LOADI = 6'b111111;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 10;
  localparam int unsigned RD_MSB  = 9;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 4;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StOpread,
    StExec,
    StWb,
    StErr
  } state_e;

  // True for opcodes that are forwarded to the ALU (LOADI excluded).
  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    logic res;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP,
      OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: res = 1'b1;
      default:                                       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two combinational operand reads, one combinational debug
// read and one synchronous write port, synchronously cleared by reset.
import alu_pkg::*;

module alu_regfile (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    rs1_addr,
  input  logic [1:0]    rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [1:0]    wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external 8-bit combinational ALU: accepts one
// instruction at a time, stages operands, captures the result, writes back.
import alu_pkg::*;

module alu_issue_ctrl (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [IW-1:0]  instr,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  output logic           done,
  output logic [1:0]     done_rd,
  output logic [DW-1:0]  done_data,
  output logic           err,
  input  logic [1:0]     dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  state_e         state_q, state_d;
  logic [IW-1:0]  instr_q;
  logic [DW-1:0]  wb_data_q;
  logic [DW-1:0]  alu_a_q, alu_b_q;
  logic [OPW-1:0] alu_op_q;
  logic [DW-1:0]  rs1_data, rs2_data;
  logic           reg_we;

  logic [OPW-1:0] op;
  logic [1:0]     rd, rs1, rs2;
  logic [DW-1:0]  imm;

  assign op  = instr_q[OP_MSB:OP_LSB];
  assign rd  = instr_q[RD_MSB:RD_LSB];
  assign rs1 = instr_q[RS1_MSB:RS1_LSB];
  assign rs2 = instr_q[RS2_MSB:RS2_LSB];
  assign imm = instr_q[IMM_MSB:IMM_LSB];

  alu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (reg_we),
    .wr_addr  (rd),
    .wr_data  (wb_data_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      wb_data_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && instr_valid) begin
        instr_q <= instr;
      end
      // Immediate is staged unconditionally; EXEC overwrites it for ALU ops.
      if (state_q == StDecode) begin
        wb_data_q <= imm;
      end
      if (state_q == StOpread) begin
        alu_a_q  <= rs1_data;
        alu_b_q  <= rs2_data;
        alu_op_q <= op;
      end
      if (state_q == StExec) begin
        wb_data_q <= alu_result;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    reg_we      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    done_rd     = '0;
    done_data   = '0;
    case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op == OP_LOADI) begin
          state_d = StWb;
        end else if (is_alu_op(op)) begin
          state_d = StOpread;
        end else begin
          state_d = StErr;
        end
      end
      StOpread: state_d = StExec;
      StExec:   state_d = StWb;
      StWb: begin
        reg_we    = 1'b1;
        done      = 1'b1;
        done_rd   = rd;
        done_data = wb_data_q;
        state_d   = StIdle;
      end
      StErr: begin
        done    = 1'b1;
        err     = 1'b1;
        done_rd = rd;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: stands in for the ALU, runs a directed vector
// table, multi-cycle corner sequences and random instructions against a model.
module tb_alu_issue_ctrl;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_MUL = 6'b000010;
  localparam logic [5:0] T_DIV = 6'b000011, T_CMP = 6'b000100, T_NOT = 6'b001000;
  localparam logic [5:0] T_AND = 6'b001001, T_OR  = 6'b001010, T_XOR = 6'b001011;
  localparam logic [5:0] T_SHL = 6'b010000, T_SHR = 6'b010001, T_LDI = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [5:0]  alu_op;
  logic        done, err;
  logic [1:0]  done_rd, dbg_addr;
  logic [7:0]  done_data, dbg_data;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mregs [4];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .done        (done),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: 8-bit truncated results, divide by zero yields 0xFF.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    logic [7:0] r;
    case (op)
      T_ADD:   r = a + b;
      T_SUB:   r = a - b;
      T_MUL:   r = a * b;
      T_DIV:   r = (b == 8'd0) ? 8'hFF : a / b;
      T_CMP:   r = (a < b) ? 8'd1 : 8'd0;
      T_NOT:   r = ~a;
      T_AND:   r = a & b;
      T_OR:    r = a | b;
      T_XOR:   r = a ^ b;
      T_SHL:   r = a << b;
      T_SHR:   r = a >> b;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  function automatic bit tb_is_alu(input logic [5:0] op);
    return op inside {T_ADD, T_SUB, T_MUL, T_DIV, T_CMP, T_NOT, T_AND, T_OR, T_XOR,
                      T_SHL, T_SHR};
  endfunction

  function automatic logic [15:0] mk_r(input logic [5:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] mk_i(input logic [1:0] rd, input logic [7:0] imm);
    return {T_LDI, rd, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and check its full timeline against the model.
  task automatic run_instr(input logic [15:0] w, input bit use_exp, input logic [7:0] exp_data);
    logic [5:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] ref_v;
    bit         is_ld, legal, ok;
    int         lat;
    op    = w[15:10];
    rd    = w[9:8];
    rs1   = w[7:6];
    rs2   = w[5:4];
    is_ld = (op == T_LDI);
    legal = is_ld || tb_is_alu(op);
    ref_v = !legal ? 8'd0 : is_ld ? w[7:0] : alu_f(mregs[rs1], mregs[rs2], op);
    if (use_exp) ref_v = exp_data;
    dbg_addr    = rd;
    instr       = w;
    instr_valid = 1'b1;
    ok          = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (instr_ready) ok = 1'b1;
      tick();
    end
    instr_valid = 1'b0;
    chk("accept", 32'(ok), 32'(1));
    if (!ok) return;
    lat = (legal && !is_ld) ? 4 : 2;
    for (int c = 1; c < lat; c++) begin
      chk("busy_ready", 32'(instr_ready), 32'(0));
      chk("early_done", 32'(done), 32'(0));
      if (c == 3) begin
        chk("alu_a", 32'(alu_a), 32'(mregs[rs1]));
        chk("alu_b", 32'(alu_b), 32'(mregs[rs2]));
        chk("alu_op", 32'(alu_op), 32'(op));
      end
      tick();
    end
    chk("done", 32'(done), 32'(1));
    chk("err", 32'(err), 32'(!legal));
    chk("done_rd", 32'(done_rd), 32'(rd));
    chk("done_data", 32'(done_data), 32'(ref_v));
    chk("dbg_old", 32'(dbg_data), 32'(mregs[rd]));
    if (legal) mregs[rd] = ref_v;
    tick();
    chk("done_clear", 32'(done), 32'(0));
    chk("dbg_new", 32'(dbg_data), 32'(mregs[rd]));
    chk("ready_back", 32'(instr_ready), 32'(1));
  endtask

  task automatic check_all_regs(input string nm);
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #1;
      chk(nm, 32'(dbg_data), 32'(mregs[r]));
    end
  endtask

  typedef struct {
    logic [15:0] w;
    logic [7:0]  exp;
  } vec_t;

  vec_t tab [12];

  initial begin
    logic [5:0] legal_ops [11];
    logic [7:0] after_tab [4];
    int         dones;
    logic [5:0] op;
    legal_ops = '{T_ADD, T_SUB, T_MUL, T_DIV, T_CMP, T_NOT, T_AND, T_OR, T_XOR, T_SHL, T_SHR};
    after_tab = '{8'hFE, 8'h02, 8'h03, 8'h10};

    tab[0]  = '{mk_i(2'd1, 8'h05), 8'h05};
    tab[1]  = '{mk_i(2'd2, 8'h03), 8'h03};
    tab[2]  = '{mk_r(T_ADD, 2'd3, 2'd1, 2'd2), 8'h08};
    tab[3]  = '{mk_i(2'd1, 8'h03), 8'h03};
    tab[4]  = '{mk_i(2'd2, 8'h05), 8'h05};
    tab[5]  = '{mk_r(T_SUB, 2'd0, 2'd1, 2'd2), 8'hFE};
    tab[6]  = '{mk_i(2'd1, 8'h81), 8'h81};
    tab[7]  = '{mk_i(2'd2, 8'h03), 8'h03};
    tab[8]  = '{mk_r(T_SHL, 2'd3, 2'd1, 2'd2), 8'h08};
    tab[9]  = '{mk_r(T_SHR, 2'd3, 2'd1, 2'd2), 8'h10};
    tab[10] = '{mk_r(T_ADD, 2'd1, 2'd1, 2'd1), 8'h02};
    tab[11] = '{mk_r(6'b000101, 2'd2, 2'd0, 2'd0), 8'h00};

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    for (int r = 0; r < 4; r++) mregs[r] = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_done_rd", 32'(done_rd), 32'(0));
    chk("rst_done_data", 32'(done_data), 32'(0));
    chk("rst_alu", 32'({alu_a, alu_b, 2'b00, alu_op}), 32'(0));
    check_all_regs("rst_regs");

    // Directed vectors with hand-derived results.
    for (int v = 0; v < 12; v++) run_instr(tab[v].w, 1'b1, tab[v].exp);
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #1;
      chk("tab_regs", 32'(dbg_data), 32'(after_tab[r]));
    end

    // Back-to-back with instr_valid held high.
    dbg_addr    = 2'd0;
    instr       = mk_r(T_ADD, 2'd0, 2'd1, 2'd2);
    instr_valid = 1'b1;
    dones       = 0;
    chk("q_ready0", 32'(instr_ready), 32'(1));
    tick();
    instr = mk_i(2'd3, 8'h77);
    for (int c = 1; c <= 4; c++) begin
      chk("q_busy", 32'(instr_ready), 32'(0));
      if (done) dones++;
      tick();
    end
    chk("q_ready5", 32'(instr_ready), 32'(1));
    tick();
    instr_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done) dones++;
      tick();
    end
    chk("q_dones", 32'(dones), 32'(2));
    mregs[0] = alu_f(mregs[1], mregs[2], T_ADD);
    mregs[3] = 8'h77;
    check_all_regs("q_regs");

    // Reset during EXEC aborts the instruction.
    run_instr(mk_i(2'd1, 8'h11), 1'b0, 8'h00);
    run_instr(mk_i(2'd2, 8'h22), 1'b0, 8'h00);
    instr       = mk_r(T_ADD, 2'd2, 2'd1, 2'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("exec_alu_a", 32'(alu_a), 32'(8'h11));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_done", 32'(done), 32'(0));
    chk("rr_ready", 32'(instr_ready), 32'(1));
    chk("rr_alu", 32'({alu_a, alu_b, 2'b00, alu_op}), 32'(0));
    for (int r = 0; r < 4; r++) mregs[r] = 8'd0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dones++;
      tick();
    end
    chk("rr_no_done", 32'(dones), 32'(0));
    check_all_regs("rr_regs");

    // Random instructions against the model.
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 6) begin
        op = legal_ops[$urandom_range(0, 10)];
        run_instr(mk_r(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3))), 1'b0, 8'h00);
      end else if (sel <= 8) begin
        run_instr(mk_i(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))), 1'b0, 8'h00);
      end else begin
        op = 6'b000101;
        for (int k = 0; k < 20; k++) begin
          op = 6'($urandom_range(0, 62));
          if (!tb_is_alu(op)) break;
        end
        if (tb_is_alu(op)) op = 6'b000101;
        run_instr(mk_r(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3))), 1'b0, 8'h00);
      end
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end
    check_all_regs("rand_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
